// File: rtl/sw_stream_unpacker.sv
// Parses header + packed payload records from a 128-bit FWFT stream and emits one character per cycle.
// Optional statistics counters (stat_seqs, stat_chars, stat_clr) are enabled by defining SW_UNPACK_STATS_EN.
module sw_stream_unpacker #(
    parameter int          CHAR_BITS = 2,
    parameter logic [7:0]  MAGIC     = 8'h5A
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_rdy,
    input  logic [127:0]         s_data,
    output logic                 s_en,
    output logic                 out_valid,
    output logic [CHAR_BITS-1:0] out_char,
    output logic                 out_last,
    output logic [15:0]          out_seq_id,
    input  logic                 out_ready,
    output logic                 hdr_err,
    output logic                 busy
`ifdef SW_UNPACK_STATS_EN
    ,
    input  logic                 stat_clr,
    output logic [31:0]          stat_seqs,
    output logic [31:0]          stat_chars
`endif
);

    localparam int CPW   = 128 / CHAR_BITS;
    localparam int IDX_W = $clog2(CPW);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CPW - 1);

    typedef enum logic [1:0] {IDLE, EMIT, FETCH} state_t;

    state_t             state_reg;
    logic [127:0]       shift_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [31:0]        remaining_reg;
    logic [15:0]        seq_id_reg;
    logic               hdr_err_reg;
    logic               valid_reg;
    logic               last_reg;

    logic               hs;
    logic               word_done;
    logic               is_final;
    logic               magic_ok;
    logic [31:0]        hdr_len;

    assign hs        = valid_reg && out_ready;
    assign word_done = (idx_reg == LAST_IDX);
    assign is_final  = (remaining_reg == 32'd1);
    assign magic_ok  = (s_data[127:120] == MAGIC);
    assign hdr_len   = s_data[31:0];

    // In EMIT the next word is popped only by the handshake that exhausts the current one.
    always_comb begin
        s_en = 1'b0;
        case (state_reg)
            IDLE:    s_en = s_rdy;
            FETCH:   s_en = s_rdy;
            EMIT:    s_en = hs && !is_final && word_done && s_rdy;
            default: s_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            idx_reg       <= '0;
            remaining_reg <= '0;
            seq_id_reg    <= '0;
            hdr_err_reg   <= 1'b0;
            valid_reg     <= 1'b0;
            last_reg      <= 1'b0;
        end else begin
            hdr_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (s_en) begin
                        if (!magic_ok) begin
                            hdr_err_reg <= 1'b1;
                        end else if (hdr_len != 32'd0) begin
                            seq_id_reg    <= s_data[47:32];
                            remaining_reg <= hdr_len;
                            state_reg     <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (s_en) begin
                        shift_reg <= s_data;
                        idx_reg   <= '0;
                        valid_reg <= 1'b1;
                        last_reg  <= is_final;
                        state_reg <= EMIT;
                    end
                end
                EMIT: begin
                    if (hs) begin
                        remaining_reg <= remaining_reg - 32'd1;
                        if (is_final) begin
                            shift_reg <= shift_reg >> CHAR_BITS;
                            valid_reg <= 1'b0;
                            last_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            last_reg <= (remaining_reg == 32'd2);
                            if (!word_done) begin
                                shift_reg <= shift_reg >> CHAR_BITS;
                                idx_reg   <= idx_reg + 1'b1;
                            end else if (s_rdy) begin
                                shift_reg <= s_data;
                                idx_reg   <= '0;
                            end else begin
                                valid_reg <= 1'b0;
                                state_reg <= FETCH;
                            end
                        end
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    last_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign out_valid  = valid_reg;
    assign out_char   = shift_reg[CHAR_BITS-1:0];
    assign out_last   = last_reg;
    assign out_seq_id = seq_id_reg;
    assign hdr_err    = hdr_err_reg;
    assign busy       = (state_reg != IDLE);

`ifdef SW_UNPACK_STATS_EN
    logic [31:0] stat_seqs_reg;
    logic [31:0] stat_chars_reg;

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_seqs_reg  <= '0;
            stat_chars_reg <= '0;
        end else if (stat_clr) begin
            stat_seqs_reg  <= '0;
            stat_chars_reg <= '0;
        end else if (hs) begin
            stat_chars_reg <= stat_chars_reg + 32'd1;
            if (is_final) begin
                stat_seqs_reg <= stat_seqs_reg + 32'd1;
            end
        end
    end

    assign stat_seqs  = stat_seqs_reg;
    assign stat_chars = stat_chars_reg;
`endif

endmodule

// File: tb/tb_sw_stream_unpacker.sv
// Directed bench for sw_stream_unpacker (CHAR_BITS=2); covers stats ports when SW_UNPACK_STATS_EN is defined.
module tb_sw_stream_unpacker;

    localparam int CB  = 2;
    localparam int CPW = 128 / CB;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_rdy;
    logic [127:0]  s_data;
    logic          s_en;
    logic          out_valid;
    logic [CB-1:0] out_char;
    logic          out_last;
    logic [15:0]   out_seq_id;
    logic          out_ready;
    logic          hdr_err;
    logic          busy;
`ifdef SW_UNPACK_STATS_EN
    logic          stat_clr;
    logic [31:0]   stat_seqs;
    logic [31:0]   stat_chars;
`endif

    always #5 clk = ~clk;

    sw_stream_unpacker #(.CHAR_BITS(CB), .MAGIC(8'h5A)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_rdy      (s_rdy),
        .s_data     (s_data),
        .s_en       (s_en),
        .out_valid  (out_valid),
        .out_char   (out_char),
        .out_last   (out_last),
        .out_seq_id (out_seq_id),
        .out_ready  (out_ready),
        .hdr_err    (hdr_err),
        .busy       (busy)
`ifdef SW_UNPACK_STATS_EN
        ,
        .stat_clr   (stat_clr),
        .stat_seqs  (stat_seqs),
        .stat_chars (stat_chars)
`endif
    );

    logic [127:0] fifo[$];
    int           exp_q[$];
    int           exp_len;
    logic [15:0]  exp_id;
    int           got_char[$];
    int           got_last[$];
    int           got_seq[$];
    int           stall_pts[$];
    int           stall_left;
    int           tick_no, n_pops, n_valid, n_hdr_err, n_sen_bad;
    int           first_valid_tick, last_hs_tick, busy_fall_tick, hdr_err_tick, first_pop_tick;
    int           n_stall_ticks, n_stall_sen, n_stall_chg;
    logic         busy_prev;
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk_hdr(input logic [7:0] magic, input logic [15:0] id,
                                            input logic [31:0] len);
        return {magic, 72'h0, id, len};
    endfunction

    task automatic drive_fifo();
        s_rdy  = (fifo.size() != 0);
        s_data = s_rdy ? fifo[0] : '0;
    endtask

    task automatic clear_run_state();
        got_char.delete(); got_last.delete(); got_seq.delete();
        tick_no = 0; n_pops = 0; n_valid = 0; n_hdr_err = 0; n_sen_bad = 0;
        first_valid_tick = -1; last_hs_tick = -1; busy_fall_tick = -1;
        hdr_err_tick = -1; first_pop_tick = -1;
        n_stall_ticks = 0; n_stall_sen = 0; n_stall_chg = 0; stall_left = 0;
        busy_prev = busy;
    endtask

    // Samples at the falling edge, then applies the upstream pop after the rising edge.
    task automatic tick();
        logic pop;
        logic hs;
        int   k;
        @(negedge clk);
        pop = s_en;
        hs  = out_valid && out_ready;
        if (s_en && !s_rdy) n_sen_bad++;
        if (out_valid) begin
            n_valid++;
            if (first_valid_tick < 0) first_valid_tick = tick_no;
        end
        if (hdr_err) begin
            n_hdr_err++;
            if (hdr_err_tick < 0) hdr_err_tick = tick_no;
        end
        if (busy_prev && !busy) busy_fall_tick = tick_no;
        busy_prev = busy;
        if (pop) begin
            n_pops++;
            if (first_pop_tick < 0) first_pop_tick = tick_no;
        end
        if (out_valid && !out_ready) begin
            n_stall_ticks++;
            if (s_en) n_stall_sen++;
            k = got_char.size();
            if (k < exp_len && (out_char !== CB'(exp_q[k]) || out_last !== (k == exp_len - 1)))
                n_stall_chg++;
        end
        if (hs) begin
            got_char.push_back(int'(out_char));
            got_last.push_back(int'(out_last));
            got_seq.push_back(int'(out_seq_id));
            last_hs_tick = tick_no;
        end
        @(posedge clk);
        #1;
        if (pop && fifo.size() > 0) void'(fifo.pop_front());
        drive_fifo();
        tick_no++;
    endtask

    task automatic run(input int budget);
        int   quiet;
        logic done;
        clear_run_state();
        drive_fifo();
        quiet = 0;
        done  = 1'b0;
        for (int t = 0; t < budget; t++) begin
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else if (out_valid && stall_pts.size() > 0 && stall_pts[0] == got_char.size()) begin
                void'(stall_pts.pop_front());
                out_ready  = 1'b0;
                stall_left = 1;
            end else begin
                out_ready = 1'b1;
            end
            tick();
            if (fifo.size() == 0 && !busy && !out_valid) quiet++;
            else quiet = 0;
            if (quiet >= 3) begin
                done = 1'b1;
                break;
            end
        end
        check("run_done", done, 1'b1);
    endtask

    task automatic prep_seq(input int len, input logic [15:0] id, input int seed);
        int nw;
        logic [127:0] wd;
        exp_q.delete();
        for (int i = 0; i < len; i++) exp_q.push_back((i * 3 + i / 7 + seed) % 4);
        exp_len = len;
        exp_id  = id;
        fifo.push_back(mk_hdr(8'h5A, id, len));
        nw = (len + CPW - 1) / CPW;
        for (int w = 0; w < nw; w++) begin
            wd = '0;
            for (int c = 0; c < CPW; c++) begin
                if (w * CPW + c < len) wd[c*CB +: CB] = CB'(exp_q[w * CPW + c]);
                else                   wd[c*CB +: CB] = '1;
            end
            fifo.push_back(wd);
        end
    endtask

    task automatic verify(input string name, input int exp_pops);
        int bad_c, bad_l, bad_s;
        bad_c = 0; bad_l = 0; bad_s = 0;
        for (int i = 0; i < got_char.size(); i++) begin
            if (i < exp_len && got_char[i] != exp_q[i]) bad_c++;
            if (got_last[i] != int'(i == exp_len - 1)) bad_l++;
            if (got_seq[i] != int'(exp_id)) bad_s++;
        end
        $display("seq %s: id=0x%0h chars=%0d pops=%0d", name, exp_id, got_char.size(), n_pops);
        check({name, "_count"}, got_char.size(), exp_len);
        check({name, "_chars"}, bad_c, 0);
        check({name, "_last"},  bad_l, 0);
        check({name, "_seqid"}, bad_s, 0);
        check({name, "_pops"},  n_pops, exp_pops);
        check({name, "_sen_rdy"}, n_sen_bad, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; s_rdy = 1'b0; s_data = '0; out_ready = 1'b0;
`ifdef SW_UNPACK_STATS_EN
        stat_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_hdr_err", hdr_err, 1'b0);
        check("rst_char", out_char, 2'd0);
        check("rst_last", out_last, 1'b0);
        check("rst_seq_id", out_seq_id, 16'h0);
        check("rst_s_en", s_en, 1'b0);
        rst = 1'b1;

        // Five chars from one payload word 0x3E4 -> 0,1,2,3,3.
        fifo.push_back(mk_hdr(8'h5A, 16'h0042, 32'd5));
        fifo.push_back(128'h3E4);
        exp_q = '{0, 1, 2, 3, 3};
        exp_len = 5;
        exp_id = 16'h0042;
        run(50);
        verify("basic", 2);
        check("basic_latency", first_valid_tick - first_pop_tick, 2);
        check("basic_contig", last_hs_tick - first_valid_tick + 1, 5);

        // 130 chars across three words with no bubbles.
        prep_seq(130, 16'h1234, 1);
        run(300);
        verify("long", 4);
        check("long_valid_cycles", n_valid, 130);
        check("long_contig", last_hs_tick - first_valid_tick + 1, 130);
        check("long_busy_fall", busy_fall_tick - last_hs_tick, 1);

        // Bad magic, then a good len=1 header.
        fifo.push_back(mk_hdr(8'hA5, 16'h0BAD, 32'd5));
        fifo.push_back(mk_hdr(8'h5A, 16'h0007, 32'd1));
        fifo.push_back(128'h1);
        exp_q = '{1};
        exp_len = 1;
        exp_id = 16'h0007;
        run(50);
        verify("badmagic", 3);
        check("badmagic_err_cycles", n_hdr_err, 1);
        check("badmagic_err_time", hdr_err_tick - first_pop_tick, 1);
        check("badmagic_valid_cycles", n_valid, 1);

        // Zero-length header consumed silently, then len=1.
        fifo.push_back(mk_hdr(8'h5A, 16'h0009, 32'd0));
        fifo.push_back(mk_hdr(8'h5A, 16'h0033, 32'd1));
        fifo.push_back({126'h0, 2'd2});
        exp_q = '{2};
        exp_len = 1;
        exp_id = 16'h0033;
        run(50);
        verify("zerolen", 3);
        check("zerolen_hdr_err", n_hdr_err, 0);

        // Two-cycle stalls mid-word, at the word boundary and on the last char.
        prep_seq(66, 16'h0066, 2);
        stall_pts = '{2, 63, 65};
        run(200);
        verify("stall", 3);
        check("stall_ticks", n_stall_ticks, 6);
        check("stall_s_en", n_stall_sen, 0);
        check("stall_stable", n_stall_chg, 0);

        // Asynchronous reset mid-sequence.
        prep_seq(10, 16'h0077, 3);
        clear_run_state();
        drive_fifo();
        out_ready = 1'b1;
        for (int t = 0; t < 30 && got_char.size() < 3; t++) tick();
        check("rst_mid_progress", got_char.size(), 3);
        #3;
        rst = 1'b0;
        #1;
        check("rst_mid_valid", out_valid, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_last", out_last, 1'b0);
`ifdef SW_UNPACK_STATS_EN
        check("rst_mid_stat_chars", stat_chars, 32'd0);
        check("rst_mid_stat_seqs", stat_seqs, 32'd0);
`endif
        @(posedge clk);
        #3;
        rst = 1'b1;
        fifo.delete();
        drive_fifo();
        $display("seq reset: id=0x%0h abandoned after %0d chars", exp_id, got_char.size());

`ifdef SW_UNPACK_STATS_EN
        prep_seq(3, 16'h0011, 0);
        run(50);
        verify("stats", 2);
        check("stats_chars", stat_chars, 32'd3);
        check("stats_seqs", stat_seqs, 32'd1);
        prep_seq(1, 16'h0012, 1);
        clear_run_state();
        drive_fifo();
        out_ready = 1'b1;
        for (int t = 0; t < 20 && got_char.size() == 0; t++) begin
            stat_clr = out_valid && out_last;
            tick();
        end
        stat_clr = 1'b0;
        tick();
        check("stats_clr_count", got_char.size(), 1);
        check("stats_clr_chars", stat_chars, 32'd0);
        check("stats_clr_seqs", stat_seqs, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
